// File: rtl/smol_boi_pkg.sv
// Shared types and constants for the smol_boi SPI echo slave.
package smol_boi_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/smol_boi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detect
// taken from the last stage against one extra delay flop.
module smol_boi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            sync_q[i] <= sync_q[i-1];
         end
         sync_q[0] <= d_i;
         dly_q     <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = q_o & ~dly_q;
   assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/smol_boi.sv
// SPI mode-0 slave that echoes each received word back on MISO during the
// following word, across CS frames; received words also appear on rx_data.
module smol_boi
   import smol_boi_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SCLK,
   input  logic             CS,
   input  logic             MOSI,
   output logic             MISO,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid
);

   localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   smol_boi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(CLK), .rst_n(rst_n_int), .d_i(SCLK),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   smol_boi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(CLK), .rst_n(rst_n_int), .d_i(CS),
      .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   smol_boi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(CLK), .rst_n(rst_n_int), .d_i(MOSI),
      .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [WIDTH-1:0] rx_sr_q, tx_q, echo_q, rx_data_q;
   logic             rx_valid_q;
   logic [WIDTH-1:0] rx_word;

   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = SHIFT;
         SHIFT:   if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // MISO is gated with the raw pin so it drops as soon as CS deasserts.
   always_comb begin
      MISO = 1'b0;
      if (state_q == SHIFT && !CS) begin
         MISO = tx_q[WIDTH-1];
      end
   end

   assign rx_word  = {rx_sr_q[WIDTH-2:0], mosi_s};
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   // CS edges win over any SCLK edge seen in the same cycle.
   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         bit_cnt_q  <= '0;
         rx_sr_q    <= '0;
         tx_q       <= '0;
         echo_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (cs_fall) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_q      <= echo_q;
         end else if (cs_rise) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
         end else if (state_q == SHIFT) begin
            if (sclk_rise) begin
               rx_sr_q <= rx_word;
               if (bit_cnt_q == LAST_CNT) begin
                  bit_cnt_q  <= '0;
                  rx_data_q  <= rx_word;
                  echo_q     <= rx_word;
                  rx_valid_q <= 1'b1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            // A zero count on a falling edge means a word just completed.
            if (sclk_fall) begin
               tx_q <= (bit_cnt_q == '0) ? echo_q : {tx_q[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   logic sync_level_unused;
   assign sync_level_unused = sclk_s ^ cs_s;

endmodule

// File: tb/tb_smol_boi.sv
// Scoreboard bench for smol_boi: a bit-banged SPI master pushes expected
// rx words and echo words; two monitors pop and compare.
module tb_smol_boi;

   logic       CLK = 1'b0;
   logic       RST_N, SCLK, CS, MOSI;
   logic       MISO;
   logic [7:0] rx_data;
   logic       rx_valid;

   smol_boi #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
      .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid)
   );

   always #10 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic [7:0] echo_m = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         MOSI = b[i];
         #200 SCLK = 1'b1;
         #200 SCLK = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      exp_miso.push_back(echo_m);
      exp_rx.push_back(b);
      echo_m = b;
      $display("send 0x%02h expect echo 0x%02h", b, exp_miso[$]);
      send_bits(b, 8);
   endtask

   task automatic frame_begin();
      CS = 1'b0;
      #200;
   endtask

   task automatic frame_end();
      #200 CS = 1'b1;
      MOSI = 1'b0;
      #400;
   endtask

   // rx monitor: one pop per rx_valid pulse, and each pulse must be one cycle.
   initial begin : rx_mon
      logic prev;
      logic [7:0] e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (rx_valid && !prev) begin
            if (exp_rx.size() == 0) begin
               check("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_rx.pop_front();
               check("rx_data", {24'd0, rx_data}, {24'd0, e});
               $display("rx_valid rx_data=0x%02h", rx_data);
            end
         end else if (rx_valid && prev) begin
            check("rx_valid_width", 32'd2, 32'd1);
         end else if (!rx_valid && prev) begin
            check("rx_valid_end", {31'd0, rx_valid}, 32'd0);
         end
         prev = rx_valid;
      end
   end

   // MISO monitor: master-side sampling on SCLK rise, MSB first.
   initial begin : miso_mon
      int nbits;
      logic [7:0] word;
      logic [7:0] e;
      nbits = 0;
      word  = 8'h00;
      forever begin
         @(posedge SCLK or posedge CS or negedge RST_N);
         if (!RST_N || CS) begin
            nbits = 0;
         end else if (SCLK) begin
            word = {word[6:0], MISO};
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               if (exp_miso.size() == 0) begin
                  check("miso_unexpected_word", 32'd1, 32'd0);
               end else begin
                  e = exp_miso.pop_front();
                  check("miso_word", {24'd0, word}, {24'd0, e});
                  $display("miso word 0x%02h", word);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] r;
      RST_N = 1'b0;
      SCLK  = 1'b0;
      CS    = 1'b1;
      MOSI  = 1'b0;
      repeat (5) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_miso", {31'd0, MISO}, 32'd0);

      frame_begin();
      send_byte(8'hA5);
      send_byte(8'h3C);
      frame_end();

      frame_begin();
      send_byte(8'hFF);
      frame_end();

      // Partial word: discarded, rx_data and echo untouched.
      frame_begin();
      send_bits(8'h0F, 5);
      frame_end();
      check("partial_rx_data", {24'd0, rx_data}, 32'h0000_00FF);

      frame_begin();
      send_byte(8'h81);
      frame_end();

      // Reset in the middle of a word.
      frame_begin();
      send_bits(8'h66, 4);
      RST_N = 1'b0;
      #1;
      check("midreset_miso", {31'd0, MISO}, 32'd0);
      check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
      #99 CS = 1'b1;
      MOSI = 1'b0;
      #100 RST_N = 1'b1;
      echo_m = 8'h00;
      #400;

      frame_begin();
      send_byte(8'h5A);
      frame_end();

      for (int f = 0; f < 16; f++) begin
         frame_begin();
         r = 8'($urandom_range(0, 255));
         send_byte(r);
         r = 8'($urandom_range(0, 255));
         send_byte(r);
         frame_end();
      end

      repeat (50) @(negedge CLK);
      check("rx_queue_drained", exp_rx.size(), 32'd0);
      check("miso_queue_drained", exp_miso.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smol_boi.md
SMOL_BOI -- requirements
Module: smol_boi

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits for each shift frame.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of each input synchronizer.
REQ-003 CLK  input  1  system clock; all state updates on the rising edge; one clock only.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 SCLK  input  1  SPI serial clock from the master; asynchronous to CLK.
REQ-006 CS  input  1  SPI chip select, active-low; asynchronous to CLK.
REQ-007 MOSI  input  1  SPI master-out data, MSB first.
REQ-008 MISO  output  1  SPI slave-out data, MSB first; driven to 0 whenever CS is high (no tristate).
REQ-009 rx_data  output  WIDTH  last complete word received on MOSI.
REQ-010 rx_valid  output  1  one-CLK pulse when rx_data updates.

Function
REQ-011 SPI mode 0 (CPOL=0, CPHA=0): sample MOSI on SCLK rising edge; change MISO after SCLK falling edge.
REQ-012 SCLK, CS and MOSI each pass through a SYNC_STAGES-deep synchronizer; edges are detected from the last stage versus one extra delay flop, so a pin edge is acted on 3 CLK cycles later.
REQ-013 SCLK high and low phases are each at least 4 CLK periods; faster SCLK is out of scope.
REQ-014 States: IDLE (CS high) and SHIFT (CS low); IDLE->SHIFT on a detected CS falling edge; SHIFT->IDLE on a detected CS rising edge.
REQ-015 On IDLE->SHIFT: bit counter=0, tx shift register loads the echo register, MISO presents echo MSB.
REQ-016 In SHIFT, each detected SCLK rising edge shifts the synchronized MOSI into the LSB of the rx shift register and increments the bit counter.
REQ-017 When the counter reaches WIDTH: rx_data and the echo register take the assembled word, rx_valid pulses for 1 CLK the following cycle, and the counter wraps to 0.
REQ-018 Each detected SCLK falling edge in SHIFT shifts tx left by one; if the counter is 0 after a wrap, tx reloads from the echo register instead.
REQ-019 Loopback latency: word N received on MOSI is returned on MISO during word N+1, either in the same CS frame or in the next one.
REQ-020 CS rising mid-word: the partial word is discarded, no rx_valid, echo and rx_data unchanged, counter cleared.
REQ-021 CS edge and SCLK edge detected in the same cycle: the CS edge takes priority and the SCLK edge is ignored.
REQ-022 SCLK edges while in IDLE are ignored.
REQ-023 Words are processed MSB first in both directions; no parity and no framing bits.

Reset
REQ-024 RST_N low asynchronously clears all synchronizers to the idle level (SCLK=0, CS=1, MOSI=0), state=IDLE, counter=0, rx/tx/echo registers=0, rx_data=0, rx_valid=0, MISO=0.
REQ-025 Reset release is synchronized internally; the first CS falling edge is accepted at least SYNC_STAGES+1 cycles after release.
REQ-026 Reset mid-frame aborts the frame; no rx_valid is generated.

Structure
REQ-027 A shared package holds the state enum (IDLE, SHIFT) and the WIDTH default constant.
REQ-028 One sub-module, smol_boi_sync, implements the synchronizer plus rise/fall edge detect and is instantiated three times.
REQ-029 Everything else is a single always_ff datapath plus the next-state logic in smol_boi.

Verification
REQ-030 After reset, CS low, send 0xA5 -> MISO bits all 0, rx_data=0xA5, one rx_valid pulse.
REQ-031 Same frame, send 0x3C after 0xA5 -> MISO returns 10100101, rx_data=0x3C.
REQ-032 CS high, then a new frame sending 0xFF -> MISO returns 0x3C (echo kept across frames).
REQ-033 Send 5 bits of 0x0F, then raise CS -> no rx_valid, rx_data unchanged; next frame echo unchanged.
REQ-034 Assert RST_N low mid-word -> all outputs 0 immediately; after release, first echo is 0x00.
REQ-035 CLK 20 ns, SCLK 400 ns, randomized bytes over 16 frames -> every MISO word equals the previous MOSI word.
